// File: rtl/hack_memory.sv
// Hack computer data memory: 16K-word RAM, 8K-word screen buffer and keyboard register
// behind one CPU port, plus an independent read-only screen port for the display.
module hack_memory (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [14:0] address,
    output logic [15:0] out,
    input  logic [15:0] key,
    input  logic [12:0] screen_addr,
    output logic [15:0] screen_data
);

    localparam logic [14:0] KBD_ADDR = 15'h6000;

    logic [15:0] ram        [0:16383];
    logic [15:0] screen_mem [0:8191];

    logic [15:0] kbd_p0;
    logic        write_ok;

    logic ram_sel;
    logic scr_sel;
    logic kbd_sel;
    logic ram_we;
    logic scr_we;

    assign ram_sel = ~address[14];
    assign scr_sel = (address[14:13] == 2'b10);
    assign kbd_sel = (address == KBD_ADDR);

    // write_ok clears with reset and sets on the first edge after release,
    // so the earliest write lands on the second edge after RST_N rises.
    assign ram_we = load & write_ok & ram_sel;
    assign scr_we = load & write_ok & scr_sel;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            kbd_p0   <= 16'h0000;
            write_ok <= 1'b0;
        end else begin
            kbd_p0   <= key;
            write_ok <= 1'b1;
        end
    end

    // Arrays carry no reset so they map onto sync-write / async-read memory.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[address[13:0]] <= in;
        end
        if (scr_we) begin
            screen_mem[address[12:0]] <= in;
        end
    end

    always_comb begin
        out = 16'h0000;
        if (ram_sel) begin
            out = ram[address[13:0]];
        end else if (scr_sel) begin
            out = screen_mem[address[12:0]];
        end else if (kbd_sel) begin
            out = kbd_p0;
        end
    end

    assign screen_data = screen_mem[screen_addr];

endmodule

// File: tb/tb_hack_memory.sv
// Bench for hack_memory: memory-map vector table, read-during-write and reset
// sequences, then randomized traffic against an address-range reference model.
module tb_hack_memory;

    logic        CLK;
    logic        RST_N;
    logic [15:0] in;
    logic        load;
    logic [14:0] address;
    logic [15:0] out;
    logic [15:0] key;
    logic [12:0] screen_addr;
    logic [15:0] screen_data;

    hack_memory dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in          (in),
        .load        (load),
        .address     (address),
        .out         (out),
        .key         (key),
        .screen_addr (screen_addr),
        .screen_data (screen_data)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    int nchk  = 0;
    int npass = 0;

    // Reference model: sparse maps of written words plus the last sampled key.
    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] kbd_m;
    int          ram_q [$];
    int          scr_q [$];

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
        logic        ld;
        logic [15:0] k;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(input logic [14:0] a, input logic [15:0] d, input logic l,
                                input logic [15:0] k, input logic [15:0] e, input string n);
        vec_t v;
        v.addr = a;
        v.data = d;
        v.ld   = l;
        v.k    = k;
        v.exp  = e;
        v.name = n;
        return v;
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    function automatic void model_write(input int a, input logic [15:0] d);
        if (a < 'h4000) begin
            ram_m[a] = d;
            ram_q.push_back(a);
        end else if (a < 'h6000) begin
            scr_m[a - 'h4000] = d;
            scr_q.push_back(a - 'h4000);
        end
    endfunction

    function automatic void model_read(input int a, output bit known, output logic [15:0] v);
        known = 1'b1;
        v     = 16'h0000;
        if (a < 'h4000) begin
            known = ram_m.exists(a);
            if (known) v = ram_m[a];
        end else if (a < 'h6000) begin
            known = scr_m.exists(a - 'h4000);
            if (known) v = scr_m[a - 'h4000];
        end else if (a == 'h6000) begin
            v = kbd_m;
        end
    endfunction

    task automatic step(input logic [14:0] a, input logic [15:0] d, input logic ld,
                        input logic [15:0] k);
        @(negedge CLK);
        address = a;
        in      = d;
        load    = ld;
        key     = k;
        @(posedge CLK);
        if (ld) model_write(int'(a), d);
        kbd_m = k;
        #1;
        load = 1'b0;
    endtask

    int          r;
    int          wa;
    int          ra;
    int          sa;
    logic [15:0] wd;
    logic [15:0] kk;
    logic        ld;
    bit          known;
    logic [15:0] mv;

    initial begin
        RST_N       = 1'b1;
        in          = 16'h0000;
        load        = 1'b0;
        address     = 15'h6000;
        key         = 16'h0000;
        screen_addr = 13'h0000;
        kbd_m       = 16'h0000;

        vecs[0] = mk(15'h0000, 16'hAAAA, 1'b1, 16'h0000, 16'hAAAA, "ram_low");
        vecs[1] = mk(15'h3FFF, 16'hBBBB, 1'b1, 16'h0000, 16'hBBBB, "ram_high");
        vecs[2] = mk(15'h4000, 16'hCCCC, 1'b1, 16'h0000, 16'hCCCC, "screen_low");
        vecs[3] = mk(15'h5FFF, 16'hDDDD, 1'b1, 16'h0000, 16'hDDDD, "screen_high");
        vecs[4] = mk(15'h6000, 16'hEEEE, 1'b1, 16'h0000, 16'h0000, "kbd_write_ignored");
        vecs[5] = mk(15'h6000, 16'h0000, 1'b0, 16'h0041, 16'h0041, "kbd_key_41");
        vecs[6] = mk(15'h6000, 16'h0000, 1'b0, 16'h0000, 16'h0000, "kbd_key_0");
        vecs[7] = mk(15'h6001, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, "unmapped_6001");
        vecs[8] = mk(15'h7FFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, "unmapped_7fff");

        // Power-on reset
        #2 RST_N = 1'b0;
        #1 check("rst_kbd", out, 16'h0000);
        address = 15'h7000;
        #1 check("rst_unmapped", out, 16'h0000);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].addr, vecs[i].data, vecs[i].ld, vecs[i].k);
            address = vecs[i].addr;
            #1 check(vecs[i].name, out, vecs[i].exp);
        end

        address = 15'h0000;
        #1 check("ram_low_kept", out, 16'hAAAA);
        address = 15'h3FFF;
        #1 check("ram_high_kept", out, 16'hBBBB);
        address = 15'h4000;
        #1 check("screen_low_kept", out, 16'hCCCC);
        screen_addr = 13'h0000;
        #1 check("screen_port_low", screen_data, 16'hCCCC);
        screen_addr = 13'h1FFF;
        #1 check("screen_port_high", screen_data, 16'hDDDD);

        // Read-during-write: old word before the edge, new word after it
        step(15'h0010, 16'h2222, 1'b1, 16'h0000);
        step(15'h4010, 16'h3333, 1'b1, 16'h0000);
        @(negedge CLK);
        address = 15'h0010;
        in      = 16'h1111;
        load    = 1'b1;
        #1 check("rdw_ram_before", out, 16'h2222);
        @(posedge CLK);
        model_write('h0010, 16'h1111);
        #1 check("rdw_ram_after", out, 16'h1111);
        @(negedge CLK);
        address     = 15'h4010;
        in          = 16'h4444;
        screen_addr = 13'h0010;
        #1 check("rdw_screen_before", screen_data, 16'h3333);
        @(posedge CLK);
        model_write('h4010, 16'h4444);
        #1 load = 1'b0;
        check("rdw_screen_after", screen_data, 16'h4444);
        check("rdw_screen_out", out, 16'h4444);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       wa = $urandom_range(0, 'h3FFF);
            else if (r < 8)  wa = $urandom_range('h4000, 'h5FFF);
            else if (r == 8) wa = 'h6000;
            else             wa = $urandom_range('h6001, 'h7FFF);
            wd = 16'($urandom);
            ld = ($urandom_range(0, 3) != 0);
            kk = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000;
            step(15'(wa), wd, ld, kk);
            case ($urandom_range(0, 3))
                0:       ra = ram_q[$urandom_range(0, ram_q.size() - 1)];
                1:       ra = 'h4000 + scr_q[$urandom_range(0, scr_q.size() - 1)];
                2:       ra = 'h6000;
                default: ra = $urandom_range(0, 'h7FFF);
            endcase
            sa = scr_q[$urandom_range(0, scr_q.size() - 1)];
            address     = 15'(ra);
            screen_addr = 13'(sa);
            #1;
            model_read(ra, known, mv);
            if (known) check("rand_out", out, mv);
            check("rand_screen", screen_data, scr_m[sa]);
        end

        // Mid-cycle reset: KBD clears at once, writes blocked, resume on 2nd edge
        step(15'h0020, 16'h1357, 1'b1, 16'h1234);
        step(15'h0021, 16'h2468, 1'b1, 16'h1234);
        address = 15'h6000;
        #1 check("kbd_pre_rst", out, 16'h1234);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1 check("kbd_async_clear", out, 16'h0000);
        address = 15'h0020;
        in      = 16'hFFFF;
        load    = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check("ram_blocked_in_rst", out, 16'h1357);
        address = 15'h6000;
        #1 check("kbd_held_in_rst", out, 16'h0000);
        @(negedge CLK);
        RST_N   = 1'b1;
        address = 15'h0020;
        in      = 16'hAAAA;
        load    = 1'b1;
        @(posedge CLK);
        #1 check("edge1_no_write", out, 16'h1357);
        @(negedge CLK);
        address = 15'h0021;
        in      = 16'hBBBB;
        @(posedge CLK);
        #1 load = 1'b0;
        check("edge2_write", out, 16'hBBBB);
        address = 15'h0020;
        #1 check("edge2_other_kept", out, 16'h1357);
        address = 15'h6000;
        #1 check("kbd_after_rst", out, 16'h1234);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
